// File: rtl/mul_by_add_pkg.sv
// Shared types for the shift-free multiply-by-repeated-add controller.
// Holds the FSM state encoding and the datapath/iteration width.
package mul_by_add_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      LDA  = 2'd0,
      LDB  = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_t;

   // Every state except the idle operand-A slot belongs to an operation in flight.
   function automatic logic is_busy(input state_t s);
      return (s != LDA);
   endfunction

endpackage

// File: rtl/mba_iter_cnt.sv
// Add-cycle counter: clears on the multiplier load, counts each product add, holds otherwise.
// Registered count, one-cycle update latency; no backpressure, reads as zero while rst is high.
module mba_iter_cnt
   import mul_by_add_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [DATA_W-1:0] cnt
);

   logic [DATA_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + DATA_W'(1);
      end
   end

   assign cnt = rst ? '0 : cnt_q;

endmodule

// File: rtl/mul_by_add_ctrl.sv
// Control FSM for a multiply-by-repeated-add datapath (optional iter_cnt under MBA_ITER_CNT_EN).
// Controls are same-cycle decodes of state; in_valid/out_ready stall the LDA/LDB and DONE states.
module mul_by_add_ctrl
   import mul_by_add_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              eqz,
   output logic              ldA,
   output logic              ldB,
   output logic              clrP,
   output logic              ldP,
   output logic              decB,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
`ifdef MBA_ITER_CNT_EN
   ,
   output logic [DATA_W-1:0] iter_cnt
`endif
);

   state_t state_q;
   state_t state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LDA;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs are forced low during reset, even before the state register has been cleared.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      ldA       = 1'b0;
      ldB       = 1'b0;
      clrP      = 1'b0;
      ldP       = 1'b0;
      decB      = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      if (!rst) begin
         busy = is_busy(state_q);
         case (state_q)
            LDA: begin
               in_ready = 1'b1;
               ldA      = in_valid;
               if (in_valid) state_d = LDB;
            end
            LDB: begin
               in_ready = 1'b1;
               ldB      = in_valid;
               clrP     = in_valid;
               if (in_valid) state_d = CALC;
            end
            CALC: begin
               // Stop on eqz so the multiplier counter is never decremented past zero.
               if (!eqz) begin
                  ldP  = 1'b1;
                  decB = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
            DONE: begin
               out_valid = 1'b1;
               if (out_ready) state_d = LDA;
            end
            default: state_d = LDA;
         endcase
      end
   end

`ifdef MBA_ITER_CNT_EN
   mba_iter_cnt u_iter_cnt (
      .clk (clk),
      .rst (rst),
      .clr (ldB),
      .inc (ldP),
      .cnt (iter_cnt)
   );
`endif

endmodule

// File: doc/mul_by_add_ctrl.md
MUL_BY_ADD_CTRL -- requirements
Module: mul_by_add_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-002 SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand beat present on the shared datapath input bus
- in_ready  out  1  controller accepts an operand beat
- eqz  in  1  datapath flag: multiplier counter == 0
- ldA  out  1  load multiplicand register
- ldB  out  1  load multiplier counter
- clrP  out  1  clear product register
- ldP  out  1  load product register (P <= P + A)
- decB  out  1  decrement multiplier counter
- out_valid  out  1  product register holds a finished result
- out_ready  in  1  consumer takes the result
- busy  out  1  multiplication in progress
- iter_cnt  out  16  add cycles in the last or current operation (MBA_ITER_CNT_EN only)

Function
REQ-003 SHALL implement FSM states LDA (idle), LDB, CALC, DONE.
REQ-004 LDA: in_ready=1; ldA = in_valid; on in_valid go to LDB, else stay.
REQ-005 LDB: in_ready=1; ldB = clrP = in_valid; on in_valid go to CALC, else stay.
REQ-006 CALC: in_ready=0; if eqz=0, ldP=decB=1 and stay; if eqz=1, ldP=decB=0 and go to DONE.
REQ-007 DONE: out_valid=1; all ld*/clrP/decB=0; on out_ready go to LDA, else hold.
REQ-008 ld*, clrP, decB, in_ready, out_valid SHALL be combinational decodes of state and inputs, with no registered delay.
REQ-009 busy SHALL be 1 in LDB, CALC and DONE, and 0 in LDA.
REQ-010 decB SHALL never assert while eqz=1; counter wrap below zero is forbidden.
REQ-011 For multiplier B, CALC SHALL last B+1 cycles, with ldP asserted for exactly B cycles.
REQ-012 B=0: CALC lasts 1 cycle, no ldP, and the result equals 0 from clrP.
REQ-013 in_valid gaps in LDA/LDB SHALL stall without side effects; in_valid is ignored in CALC and DONE.
REQ-014 out_ready is ignored outside DONE; out_valid SHALL stay stable until accepted.
REQ-015 DONE with out_ready=1 SHALL move to LDA in one cycle; a new A beat is accepted the following cycle.

Reset
REQ-016 rst SHALL force state to LDA at the next clk edge, from any state including mid-CALC.
REQ-017 While rst=1, all outputs SHALL be 0, including in_ready; iter_cnt SHALL reset to 0.
REQ-018 After reset release, the first cycle SHALL be LDA with in_ready=1.

Configuration
REQ-019 Macro MBA_ITER_CNT_EN defined: iter_cnt port present; it clears on the accepted B beat, increments on each ldP, and holds through DONE.
REQ-020 MBA_ITER_CNT_EN undefined: no iter_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-021 Package mul_by_add_pkg SHALL hold the state typedef (LDA, LDB, CALC, DONE) and the data width constant (16).
REQ-022 The optional iteration counter SHALL be sub-module mba_iter_cnt, instantiated only under MBA_ITER_CNT_EN; the FSM stays in the top module.

Verification
REQ-023 A=5, B=3, out_ready=1: expect ldA, then ldB+clrP, then ldP/decB for 3 cycles, then out_valid for 1 cycle, product=15, iter_cnt=3.
REQ-024 A=7, B=0: expect 1 CALC cycle with no ldP, then out_valid, product=0, iter_cnt=0.
REQ-025 A=2, B=4, out_ready low 5 cycles in DONE: expect out_valid held 5 cycles, no ld*/decB pulses, product=8, then LDA.
REQ-026 in_valid low 3 cycles in LDA and 2 cycles in LDB: expect no ld* pulses during the gaps and a correct product (A=9, B=2 -> 18).
REQ-027 rst asserted in CALC after 2 ldP (A=3, B=10): expect state LDA next cycle, all outputs 0 during rst, and a clean following operation (A=4, B=4 -> 16).
REQ-028 B=0xFFFF stress, A=1: expect exactly 65535 ldP, no decB when eqz=1, and product 0xFFFF.
